// File: rtl/seg_pkg.sv
// Shared types and constants for the 4-digit 7-segment display path.
// Segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
package seg_pkg;

  typedef enum logic [1:0] {
    BLANK = 2'd0,
    ARM   = 2'd1,
    SHOW  = 2'd2
  } scan_state_t;

  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [3:0] SEL_NONE = 4'hF;

  // Entry n is the pattern for nibble n; entry 15 sits in the MSBs.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational hex nibble to active-low 7-segment decoder (0-9, A, b, C, d, E, F).
module hex_to_7seg
  import seg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[hex];

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed 4-digit 7-segment scanner: BLANK -> ARM -> SHOW per digit, registered outputs.
// Optional digit blinking is compiled in when SEG_BLINK_EN is defined.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int SCAN_DIV     = 12500,
  parameter int BLANK_CYC    = 4,
  parameter int BLINK_FRAMES = 125
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] hex_in,
  input  logic [3:0] dp_mask,
  input  logic [3:0] blank_mask,
  input  logic [3:0] blink_mask,
  output logic [3:0] sel,
  output logic [6:0] seg,
  output logic       dp,
  output logic [1:0] digit_idx
);

  // One prescaler times both BLANK and SHOW, so it must hold the larger count.
  localparam int CNT_MAX = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);

  scan_state_t      state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [1:0]       idx_reg, idx_next;
  logic [3:0]       sel_reg, sel_next, sel_onehot;
  logic [6:0]       seg_reg, seg_next, dec_seg;
  logic             dp_reg, dp_next;
  logic             frame_wrap, blink_off, digit_lit;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg + 1'b1;
    idx_next   = idx_reg;
    frame_wrap = 1'b0;
    case (state_reg)
      BLANK: begin
        if (cnt_reg == BLANK_LAST) begin
          state_next = ARM;
          cnt_next   = '0;
        end
      end
      ARM: begin
        state_next = SHOW;
        cnt_next   = '0;
      end
      SHOW: begin
        if (cnt_reg == SHOW_LAST) begin
          state_next = BLANK;
          cnt_next   = '0;
          idx_next   = idx_reg + 2'd1;
          frame_wrap = (idx_reg == 2'd3);
        end
      end
      default: begin
        state_next = BLANK;
        cnt_next   = '0;
      end
    endcase
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_sel
    assign sel_onehot[gi] = (idx_next != 2'(gi));
  end

`ifdef SEG_BLINK_EN
  localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  logic [FRM_W-1:0] frame_reg;
  logic             phase_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_reg <= '0;
      phase_reg <= 1'b0;
    end else if (frame_wrap) begin
      if (frame_reg == FRM_W'(BLINK_FRAMES - 1)) begin
        frame_reg <= '0;
        phase_reg <= ~phase_reg;
      end else begin
        frame_reg <= frame_reg + 1'b1;
      end
    end
  end

  assign blink_off = phase_reg & blink_mask[idx_next];
`else
  logic unused_blink;
  assign unused_blink = ^{blink_mask, frame_wrap};
  assign blink_off    = 1'b0;
`endif

  hex_to_7seg u_dec (
    .hex (hex_in),
    .seg (dec_seg)
  );

  // Outputs are computed from the next state so each register matches the state it enters.
  assign digit_lit = (state_next == SHOW) && !blank_mask[idx_next] && !blink_off;
  assign sel_next  = (state_next == BLANK) ? SEL_NONE : sel_onehot;
  assign seg_next  = digit_lit ? dec_seg : SEG_OFF;
  assign dp_next   = digit_lit ? ~dp_mask[idx_next] : 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= BLANK;
      cnt_reg   <= '0;
      idx_reg   <= 2'd0;
      sel_reg   <= SEL_NONE;
      seg_reg   <= SEG_OFF;
      dp_reg    <= 1'b1;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      sel_reg   <= sel_next;
      seg_reg   <= seg_next;
      dp_reg    <= dp_next;
    end
  end

  assign sel       = sel_reg;
  assign seg       = seg_reg;
  assign dp        = dp_reg;
  assign digit_idx = idx_reg;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver (SCAN_DIV=8, BLANK_CYC=2, BLINK_FRAMES=2).
// Expectations follow from the digit period of 11 cycles; define SEG_BLINK_EN to match the RTL build.
module tb_seg_scan_driver;

  localparam int SCAN_DIV     = 8;
  localparam int BLANK_CYC    = 2;
  localparam int BLINK_FRAMES = 2;
  localparam int PER          = 11;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] hex_in;
  logic [3:0] dp_mask = 4'h0;
  logic [3:0] blank_mask = 4'h0;
  logic [3:0] blink_mask = 4'h0;
  logic [3:0] sel;
  logic [6:0] seg;
  logic       dp;
  logic [1:0] digit_idx;

  logic       mux_const = 1'b1;
  logic [6:0] digit_pat [4];
  int         vectors = 0;
  int         miscompares = 0;

  seg_scan_driver #(
    .SCAN_DIV     (SCAN_DIV),
    .BLANK_CYC    (BLANK_CYC),
    .BLINK_FRAMES (BLINK_FRAMES)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .hex_in     (hex_in),
    .dp_mask    (dp_mask),
    .blank_mask (blank_mask),
    .blink_mask (blink_mask),
    .sel        (sel),
    .seg        (seg),
    .dp         (dp),
    .digit_idx  (digit_idx)
  );

  always #5 clk = ~clk;

  // Display mux model: either a constant 8 or digit n returns n+1.
  always_comb begin
    hex_in = 4'h8;
    if (!mux_const) begin
      case (sel)
        4'b1110: hex_in = 4'h1;
        4'b1101: hex_in = 4'h2;
        4'b1011: hex_in = 4'h3;
        4'b0111: hex_in = 4'h4;
        default: hex_in = 4'h0;
      endcase
    end
  end

  task automatic check(input string tag, input int t, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Sample t is taken at the falling edge; t=0 is the first sample after reset release.
  task automatic run_check(input int n);
    int         pos, d, f;
    logic       blanked;
    logic [3:0] e_sel;
    logic [6:0] e_seg;
    logic       e_dp;
    logic [1:0] e_idx;
    for (int t = 0; t < n; t++) begin
      pos = t % PER;
      d   = (t / PER) % 4;
      f   = t / (4 * PER);
      blanked = blank_mask[d];
`ifdef SEG_BLINK_EN
      if (((f / BLINK_FRAMES) % 2) == 1 && blink_mask[d]) blanked = 1'b1;
`endif
      e_sel = (pos < BLANK_CYC) ? 4'hF : ~(4'b0001 << d);
      e_seg = (pos > BLANK_CYC && !blanked) ? digit_pat[d] : 7'h7F;
      e_dp  = (pos > BLANK_CYC && !blanked && dp_mask[d]) ? 1'b0 : 1'b1;
      e_idx = 2'(d);
      check("sel", t, 32'(sel), 32'(e_sel));
      check("seg", t, 32'(seg), 32'(e_seg));
      check("dp", t, 32'(dp), 32'(e_dp));
      check("digit_idx", t, 32'(digit_idx), 32'(e_idx));
      check("sel_onehot", t, 32'($countones(~sel) <= 1), 32'd1);
      @(negedge clk);
    end
  endtask

  initial begin
    #2 rst_n = 1'b0;
    @(negedge clk);
    check("rst_sel", 0, 32'(sel), 32'h0000000F);
    check("rst_seg", 0, 32'(seg), 32'h0000007F);
    check("rst_dp", 0, 32'(dp), 32'd1);
    check("rst_idx", 0, 32'(digit_idx), 32'd0);

    // hex_in tied to 8: two digits of timing with seg 00 in SHOW
    digit_pat = '{7'h00, 7'h00, 7'h00, 7'h00};
    rst_n = 1'b1;
    run_check(2 * PER + 1);

    // mux model 1..4: one full frame plus the wrap back to digit 0
    mux_const = 1'b0;
    digit_pat = '{7'h79, 7'h24, 7'h30, 7'h19};
    do_reset();
    run_check(4 * PER + 4);

    // decimal point on digit 2, digit 0 blanked
    dp_mask    = 4'b0100;
    blank_mask = 4'b0001;
    do_reset();
    run_check(4 * PER);

    // asynchronous reset in the middle of digit 2 SHOW
    dp_mask    = 4'b0000;
    blank_mask = 4'b0000;
    do_reset();
    run_check(2 * PER + 6);
    check("pre_rst_sel", 28, 32'(sel), 32'h0000000B);
    rst_n = 1'b0;
    #1;
    check("async_sel", 28, 32'(sel), 32'h0000000F);
    check("async_seg", 28, 32'(seg), 32'h0000007F);
    check("async_dp", 28, 32'(dp), 32'd1);
    check("async_idx", 28, 32'(digit_idx), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_check(PER + 2);

    // blink digit 3 over six frames
    blink_mask = 4'b1000;
    do_reset();
    run_check(6 * 4 * PER);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
